// File: rtl/envelope_detector.sv
// Stereo amplitude-envelope follower. One shared update datapath is
// time-multiplexed by a small FSM: the left channel is updated first, then the right.
module envelope_detector #(
  parameter int DATA_WIDTH    = 16,
  parameter int ATTACK_SHIFT  = 4,
  parameter int RELEASE_SHIFT = 10,
  parameter int ENV_FRAC      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] audio_left_in,
  input  logic [DATA_WIDTH-1:0] audio_right_in,
  output logic [DATA_WIDTH-1:0] env_left,
  output logic [DATA_WIDTH-1:0] env_right,
  output logic                  env_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int MW = DATA_WIDTH - 1;
  localparam int W  = MW + ENV_FRAC;
  localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);
  localparam logic [W-1:0]          ONE_W = W'(1);

  typedef enum logic [1:0] {IDLE, CALC_L, CALC_R, OUT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  logic [W-1:0]          acc_l, acc_r;

  // Saturated magnitude: the most negative code folds onto the largest positive one.
  function automatic logic [MW-1:0] sat_mag(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] neg;
    neg = ~s + ONE_D;
    if (!s[DATA_WIDTH-1])     return s[MW-1:0];
    if (neg[DATA_WIDTH-1])    return '1;
    return neg[MW-1:0];
  endfunction

  // One envelope step toward the target. A zero step is forced to 1 so the
  // accumulator always lands exactly on the target; it can never overshoot.
  function automatic logic [W-1:0] step_acc(input logic [W-1:0] acc,
                                            input logic [DATA_WIDTH-1:0] s);
    logic [W-1:0] target, diff, step;
    target = {sat_mag(s), {ENV_FRAC{1'b0}}};
    if (target > acc) begin
      diff = target - acc;
      step = diff >> ATTACK_SHIFT;
      if (step == '0) step = ONE_W;
      return acc + step;
    end else if (target < acc) begin
      diff = acc - target;
      step = diff >> RELEASE_SHIFT;
      if (step == '0) step = ONE_W;
      return acc - step;
    end
    return acc;
  endfunction

  assign busy = (state != IDLE);

  // Sequencer: latch, update left, update right, publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_l    <= '0;
      hold_r    <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      env_left  <= '0;
      env_right <= '0;
      env_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      env_valid <= 1'b0;
      // Any strobe arriving while a sample is in flight is lost.
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_valid) begin
          hold_l <= audio_left_in;
          hold_r <= audio_right_in;
          state  <= CALC_L;
        end
        CALC_L: begin
          acc_l <= step_acc(acc_l, hold_l);
          state <= CALC_R;
        end
        CALC_R: begin
          acc_r <= step_acc(acc_r, hold_r);
          state <= OUT;
        end
        OUT: begin
          env_left  <= {1'b0, acc_l[W-1:ENV_FRAC]};
          env_right <= {1'b0, acc_r[W-1:ENV_FRAC]};
          env_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
